// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM register-list memory-transfer sequencer
//
// Purpose:
//   Multi-cycle controller for load/store-multiple in the memory-access stage.
//   A start pulse latches the register list, base address and direction. The
//   controller then issues one data-memory transfer per cycle for each set bit
//   of the list, lowest register index first, and stalls the upstream pipeline
//   while it does so. A one-cycle done pulse marks completion.
//
// Optional feature (macro LMSM_BASE_WB_EN):
//   When defined, the DONE cycle also presents the auto-incremented base
//   (base + number of transfers) on base_wb_data, qualified by base_wb_en.
//   When undefined, those two ports do not exist.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle request, honoured only in IDLE
//   is_store      in   1 = SM, 0 = LM (sampled with start)
//   reg_list      in   register bitmap (sampled with start)
//   base_addr     in   first transfer address (sampled with start)
//   busy          out  sequencer not idle
//   stall         out  freeze upstream latches (transfer in progress)
//   mem_addr      out  data memory address
//   mem_read      out  LM transfer this cycle
//   mem_write     out  SM transfer this cycle
//   reg_idx       out  register-file index for this transfer
//   rf_write      out  LM register-file write enable
//   done          out  one-cycle completion pulse
//   base_wb_en    out  base writeback enable (LMSM_BASE_WB_EN only)
//   base_wb_data  out  base writeback value (LMSM_BASE_WB_EN only)

module lm_sm_sequencer #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [REG_CNT-1:0] reg_list,
  input  logic [DATA_W-1:0] base_addr,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              rf_write,
  output logic              done
`ifdef LMSM_BASE_WB_EN
  ,
  output logic              base_wb_en,
  output logic [DATA_W-1:0] base_wb_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } seqStateT;

  seqStateT             stateQ, stateD;
  logic [REG_CNT-1:0]   maskQ, maskD;
  logic [DATA_W-1:0]    baseQ, baseD;
  logic [DATA_W-1:0]    countQ, countD;
  logic                 storeQ, storeD;
  logic [IDX_W-1:0]     lowIdx;
  logic [REG_CNT-1:0]   maskRest;

  // Priority pick of the lowest set bit: scanning downward lets the lowest
  // index overwrite any higher one.
  always_comb begin
    lowIdx = '0;
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (maskQ[i]) lowIdx = IDX_W'(i);
    end
  end

  // x & (x-1) clears exactly the lowest set bit, i.e. the one served now.
  assign maskRest = maskQ & (maskQ - REG_CNT'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      maskQ  <= '0;
      baseQ  <= '0;
      countQ <= '0;
      storeQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      maskQ  <= maskD;
      baseQ  <= baseD;
      countQ <= countD;
      storeQ <= storeD;
    end
  end

  // Outputs decode purely from registered state, so an asynchronous reset
  // silences every strobe immediately.
  always_comb begin
    stateD    = stateQ;
    maskD     = maskQ;
    baseD     = baseQ;
    countD    = countQ;
    storeD    = storeQ;
    busy      = 1'b0;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_idx   = '0;
    rf_write  = 1'b0;
    done      = 1'b0;
`ifdef LMSM_BASE_WB_EN
    base_wb_en   = 1'b0;
    base_wb_data = '0;
`endif
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          maskD  = reg_list;
          baseD  = base_addr;
          storeD = is_store;
          countD = '0;
          stateD = (reg_list != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        busy      = 1'b1;
        stall     = 1'b1;
        mem_addr  = baseQ + countQ;
        reg_idx   = lowIdx;
        mem_write = storeQ;
        mem_read  = !storeQ;
        rf_write  = !storeQ;
        maskD     = maskRest;
        countD    = countQ + DATA_W'(1);
        if (maskRest == '0) stateD = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        stateD = IDLE;
`ifdef LMSM_BASE_WB_EN
        // countQ equals the number of transfers made, i.e. popcount(list).
        base_wb_en   = 1'b1;
        base_wb_data = baseQ + countQ;
`endif
      end
      default: stateD = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - scoreboard bench for lm_sm_sequencer

module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [7:0]  reg_list = '0;
  logic [15:0] base_addr = '0;
  logic        busy, stall, mem_read, mem_write, rf_write, done;
  logic [15:0] mem_addr;
  logic [2:0]  reg_idx;
`ifdef LMSM_BASE_WB_EN
  logic        base_wb_en;
  logic [15:0] base_wb_data;
`endif

  lm_sm_sequencer #(.DATA_W(16), .REG_CNT(8), .IDX_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_store(is_store),
    .reg_list(reg_list),
    .base_addr(base_addr),
    .busy(busy),
    .stall(stall),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_idx(reg_idx),
    .rf_write(rf_write),
    .done(done)
`ifdef LMSM_BASE_WB_EN
    ,
    .base_wb_en(base_wb_en),
    .base_wb_data(base_wb_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  idx;
    logic        st;
  } xferT;

  xferT xferQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outVec();
    return {7'b0, busy, stall, mem_addr, mem_read, mem_write, reg_idx, rf_write, done};
  endfunction

  task automatic checkQuiet(input string tag);
    checkEq(tag, outVec(), 32'd0);
`ifdef LMSM_BASE_WB_EN
    checkEq({tag, "_wb"}, {15'b0, base_wb_en, base_wb_data}, 32'd0);
`endif
  endtask

  // Drives one LM/SM operation. spam: re-pulse start with junk while busy.
  // abortAfter: assert reset after that many transfers (0 = run to completion).
  task automatic runOp(input logic st, input logic [7:0] list, input logic [15:0] base,
                       input bit spam, input int abortAfter);
    int   n = 0;
    int   cyc = 0;
    int   seen = 0;
    bit   gotDone = 0;
    xferT e;
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        e.addr = base + 16'(n);
        e.idx  = 3'(i);
        e.st   = st;
        xferQ.push_back(e);
        n++;
      end
    end
    @(negedge clk);
    start = 1'b1; is_store = st; reg_list = list; base_addr = base;
    while (!gotDone && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mem_read || mem_write) begin
        seen++;
        checkEq("stall", stall, 1);
        checkEq("busy", busy, 1);
        checkEq("rd_wr_excl", mem_read & mem_write, 0);
        checkEq("rf_wr_eq_rd", rf_write, mem_read);
        if (xferQ.size() == 0) begin
          checkEq("xfer_extra", {mem_read, mem_write}, 0);
        end else begin
          e = xferQ.pop_front();
          checkEq("mem_addr", mem_addr, e.addr);
          checkEq("reg_idx", reg_idx, e.idx);
          checkEq("mem_write", mem_write, e.st);
        end
        if (spam) begin
          start = 1'b1; is_store = ~st; reg_list = 8'hA5; base_addr = 16'hDEAD;
        end
        if (abortAfter != 0 && seen == abortAfter) begin
          #1 rst_n = 1'b0;
          start = 1'b0;
          #1 checkQuiet("abort_async");
          repeat (3) begin
            @(negedge clk);
            checkQuiet("abort_quiet");
          end
          rst_n = 1'b1;
          xferQ.delete();
          return;
        end
      end else begin
        checkEq("stall_nodata", stall, 0);
        gotDone = done;
        if (done) begin
          checkEq("done_cycle", cyc, n + 1);
`ifdef LMSM_BASE_WB_EN
          checkEq("base_wb_en", base_wb_en, 1);
          checkEq("base_wb_data", base_wb_data, base + 16'(n));
`endif
        end
      end
    end
    start = 1'b0;
    checkEq("done_seen", gotDone, 1);
    checkEq("xfer_missing", xferQ.size(), 0);
    xferQ.delete();
    @(negedge clk);
    checkQuiet("idle_after_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 checkQuiet("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runOp(1'b1, 8'b1000_0101, 16'h0040, 0, 0);
    runOp(1'b0, 8'hFF,        16'hFFFE, 0, 0);
    runOp(1'b1, 8'h00,        16'h1234, 0, 0);
    runOp(1'b0, 8'h0F,        16'h2000, 1, 0);
    runOp(1'b1, 8'hF0,        16'h0300, 0, 2);
    runOp(1'b1, 8'hF0,        16'h0300, 0, 0);
    runOp(1'b0, 8'h03,        16'h0010, 0, 0);
    for (int k = 0; k < 8; k++) begin
      runOp(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
